// File: rtl/bus_capture_fifo.sv
// Records completed 68000 bus cycles in a small FIFO and presents the oldest entry as a
// snapshot that stays frozen while the SPI monitor's slave select is asserted.
module bus_capture_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned PTR_W = 4
) (
   input  logic             MCLK_IN,
   input  logic             RESET_IN,
   input  logic [23:0]      CPU_ADDR_IN,
   input  logic [15:0]      CPU_DATA_IN,
   input  logic             CPU_AS_N_IN,
   input  logic             CPU_UDS_N_IN,
   input  logic             CPU_LDS_N_IN,
   input  logic             CPU_RW_IN,
   input  logic             CPU_DTACK_N_IN,
   input  logic             CAPTURE_EN_IN,
   input  logic             SPISS_IN,
   output logic [23:0]      ADDR_OUT,
   output logic [15:0]      DATA_OUT,
   output logic [3:0]       OUTPUT_SIGNAL,
   output logic             OVERFLOW,
   output logic [PTR_W:0]   COUNT
);

   localparam int unsigned      EntryW    = 43;
   localparam int unsigned      CntW      = PTR_W + 1;
   localparam logic [CntW-1:0]  CountFull = CntW'(DEPTH);
   localparam logic [CntW-1:0]  CountOne  = CntW'(1);
   localparam logic [PTR_W-1:0] PtrOne    = PTR_W'(1);

   typedef enum logic [1:0] {StIdle, StWaitAck, StSample, StWaitEnd} state_e;

   state_e            state_q, state_d;

   logic              as_meta_q, as_q;
   logic              dtack_meta_q, dtack_q;
   logic              ss_meta_q, ss_q, ss_prev_q;

   logic [EntryW-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic              overflow_q, overflow_d;

   logic [23:0]       addr_q, addr_d;
   logic [15:0]       data_q, data_d;
   logic [3:0]        sig_q, sig_d;

   logic              push_req, pop_req, push_ok, pop_ok;
   logic [EntryW-1:0] head_entry;

   // Two-flop synchronisers; idle level of all three strobes is high.
   always_ff @(posedge MCLK_IN) begin
      if (RESET_IN) begin
         as_meta_q    <= 1'b1;
         as_q         <= 1'b1;
         dtack_meta_q <= 1'b1;
         dtack_q      <= 1'b1;
         ss_meta_q    <= 1'b1;
         ss_q         <= 1'b1;
         ss_prev_q    <= 1'b1;
      end else begin
         as_meta_q    <= CPU_AS_N_IN;
         as_q         <= as_meta_q;
         dtack_meta_q <= CPU_DTACK_N_IN;
         dtack_q      <= dtack_meta_q;
         ss_meta_q    <= SPISS_IN;
         ss_q         <= ss_meta_q;
         ss_prev_q    <= ss_q;
      end
   end

   always_comb begin
      state_d  = state_q;
      push_req = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (CAPTURE_EN_IN && !as_q) begin
               state_d = StWaitAck;
            end
         end
         StWaitAck: begin
            if (!dtack_q) begin
               state_d = StSample;
            end else if (as_q) begin
               state_d = StIdle;
            end
         end
         StSample: begin
            push_req = 1'b1;
            state_d  = StWaitEnd;
         end
         StWaitEnd: begin
            if (as_q) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      pop_req    = ss_q && !ss_prev_q;
      pop_ok     = pop_req && (count_q != '0);
      // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
      push_ok    = push_req && ((count_q != CountFull) || pop_ok);
      overflow_d = overflow_q | (push_req & ~push_ok);
      wr_ptr_d   = push_ok ? wr_ptr_q + PtrOne : wr_ptr_q;
      rd_ptr_d   = pop_ok ? rd_ptr_q + PtrOne : rd_ptr_q;
      count_d    = count_q;
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CountOne;
         2'b01:   count_d = count_q - CountOne;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge MCLK_IN) begin
      if (RESET_IN) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Buses are stable by the time synced DTACK has steered the FSM into StSample.
   always_ff @(posedge MCLK_IN) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= {CPU_ADDR_IN, CPU_DATA_IN, CPU_RW_IN, CPU_UDS_N_IN, CPU_LDS_N_IN};
      end
   end

   assign head_entry = mem_q[rd_ptr_q];

   always_comb begin
      addr_d = addr_q;
      data_d = data_q;
      sig_d  = sig_q;
      if (ss_q) begin
         if (count_q != '0) begin
            addr_d = head_entry[42:19];
            data_d = head_entry[18:3];
            sig_d  = {head_entry[2:0], 1'b1};
         end else begin
            addr_d = '0;
            data_d = '0;
            sig_d  = '0;
         end
      end
   end

   always_ff @(posedge MCLK_IN) begin
      if (RESET_IN) begin
         addr_q <= '0;
         data_q <= '0;
         sig_q  <= '0;
      end else begin
         addr_q <= addr_d;
         data_q <= data_d;
         sig_q  <= sig_d;
      end
   end

   assign ADDR_OUT      = addr_q;
   assign DATA_OUT      = data_q;
   assign OUTPUT_SIGNAL = sig_q;
   assign OVERFLOW      = overflow_q;
   assign COUNT         = count_q;

endmodule

// File: tb/tb_bus_capture_fifo.sv
// Directed bench for bus_capture_fifo: capture, pop ordering, abort, overflow,
// frozen snapshot, simultaneous push/pop on a full FIFO and mid-sequence reset.
module tb_bus_capture_fifo;

   logic        clk;
   logic        rst;
   logic [23:0] cpu_addr;
   logic [15:0] cpu_data;
   logic        as_n, uds_n, lds_n, rw, dtack_n;
   logic        cap_en;
   logic        ss_n;
   logic [23:0] addr_o;
   logic [15:0] data_o;
   logic [3:0]  sig_o;
   logic        ovf_o;
   logic [4:0]  count_o;

   int checks = 0;
   int errors = 0;

   bus_capture_fifo #(
      .DEPTH(16),
      .PTR_W(4)
   ) dut (
      .MCLK_IN        (clk),
      .RESET_IN       (rst),
      .CPU_ADDR_IN    (cpu_addr),
      .CPU_DATA_IN    (cpu_data),
      .CPU_AS_N_IN    (as_n),
      .CPU_UDS_N_IN   (uds_n),
      .CPU_LDS_N_IN   (lds_n),
      .CPU_RW_IN      (rw),
      .CPU_DTACK_N_IN (dtack_n),
      .CAPTURE_EN_IN  (cap_en),
      .SPISS_IN       (ss_n),
      .ADDR_OUT       (addr_o),
      .DATA_OUT       (data_o),
      .OUTPUT_SIGNAL  (sig_o),
      .OVERFLOW       (ovf_o),
      .COUNT          (count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(1);
   endtask

   task automatic bus_cycle(input logic [23:0] a, input logic [15:0] d, input logic r,
                            input logic u, input logic l, input int ack_dly);
      cpu_addr = a;
      cpu_data = d;
      rw       = r;
      uds_n    = u;
      lds_n    = l;
      as_n     = 1'b0;
      step(ack_dly);
      dtack_n  = 1'b0;
      step(5);
      as_n     = 1'b1;
      dtack_n  = 1'b1;
      uds_n    = 1'b1;
      lds_n    = 1'b1;
      step(5);
   endtask

   task automatic ss_pulse();
      ss_n = 1'b0;
      step(4);
      ss_n = 1'b1;
      step(5);
   endtask

   initial begin
      logic [23:0] exp_a;
      logic [15:0] exp_d;

      rst      = 1'b1;
      cpu_addr = '0;
      cpu_data = '0;
      as_n     = 1'b1;
      uds_n    = 1'b1;
      lds_n    = 1'b1;
      rw       = 1'b1;
      dtack_n  = 1'b1;
      cap_en   = 1'b1;
      ss_n     = 1'b1;
      step(3);
      check("rst_addr", 48'(addr_o), 48'(24'h0));
      check("rst_data", 48'(data_o), 48'(16'h0));
      check("rst_sig", 48'(sig_o), 48'(4'b0000));
      check("rst_count", 48'(count_o), 48'(5'd0));
      check("rst_ovf", 48'(ovf_o), 48'(1'b0));
      rst = 1'b0;
      step(1);

      // Single write cycle, DTACK three clocks after AS.
      bus_cycle(24'h012344, 16'hBEEF, 1'b0, 1'b0, 1'b0, 3);
      check("wr_count", 48'(count_o), 48'(5'd1));
      check("wr_addr", 48'(addr_o), 48'(24'h012344));
      check("wr_data", 48'(data_o), 48'(16'hBEEF));
      check("wr_sig", 48'(sig_o), 48'(4'b0001));
      ss_pulse();
      check("wr_pop_count", 48'(count_o), 48'(5'd0));
      check("wr_pop_sig", 48'(sig_o), 48'(4'b0000));

      // Three reads, popped in order.
      bus_cycle(24'h000100, 16'h1111, 1'b1, 1'b0, 1'b0, 1);
      bus_cycle(24'h000102, 16'h2222, 1'b1, 1'b0, 1'b0, 2);
      bus_cycle(24'h000104, 16'h3333, 1'b1, 1'b0, 1'b0, 1);
      check("rd0_count", 48'(count_o), 48'(5'd3));
      check("rd0_addr", 48'(addr_o), 48'(24'h000100));
      check("rd0_data", 48'(data_o), 48'(16'h1111));
      check("rd0_sig", 48'(sig_o), 48'(4'b1001));
      ss_pulse();
      check("rd1_count", 48'(count_o), 48'(5'd2));
      check("rd1_addr", 48'(addr_o), 48'(24'h000102));
      check("rd1_data", 48'(data_o), 48'(16'h2222));
      ss_pulse();
      check("rd2_count", 48'(count_o), 48'(5'd1));
      check("rd2_addr", 48'(addr_o), 48'(24'h000104));
      check("rd2_data", 48'(data_o), 48'(16'h3333));
      ss_pulse();
      check("rd3_count", 48'(count_o), 48'(5'd0));
      check("rd3_sig", 48'(sig_o), 48'(4'b0000));
      check("rd3_addr", 48'(addr_o), 48'(24'h0));
      ss_pulse();
      check("empty_pop_count", 48'(count_o), 48'(5'd0));

      // Aborted cycle, then a complete cycle with capture disabled.
      as_n = 1'b0;
      step(4);
      as_n = 1'b1;
      step(5);
      check("abort_count", 48'(count_o), 48'(5'd0));
      cap_en = 1'b0;
      bus_cycle(24'h000400, 16'h7777, 1'b0, 1'b0, 1'b0, 1);
      check("capoff_count", 48'(count_o), 48'(5'd0));
      cap_en = 1'b1;
      bus_cycle(24'h000200, 16'h4444, 1'b0, 1'b0, 1'b1, 2);
      check("after_abort_count", 48'(count_o), 48'(5'd1));
      check("after_abort_addr", 48'(addr_o), 48'(24'h000200));
      check("after_abort_sig", 48'(sig_o), 48'(4'b0011));

      // Overflow: DEPTH+1 cycles without pops.
      do_reset();
      for (int i = 0; i < 17; i++) begin
         exp_a = 24'h100000 + 24'(2 * i);
         exp_d = 16'hA000 + 16'(i);
         bus_cycle(exp_a, exp_d, 1'b0, 1'b0, 1'b0, 1);
      end
      check("ovf_count", 48'(count_o), 48'(5'd16));
      check("ovf_flag", 48'(ovf_o), 48'(1'b1));
      check("ovf_head_addr", 48'(addr_o), 48'(24'h100000));
      check("ovf_head_data", 48'(data_o), 48'(16'hA000));
      ss_pulse();
      check("ovf_pop_count", 48'(count_o), 48'(5'd15));
      check("ovf_pop_flag", 48'(ovf_o), 48'(1'b1));
      check("ovf_pop_addr", 48'(addr_o), 48'(24'h100002));
      for (int k = 2; k < 16; k++) begin
         ss_pulse();
         exp_d = 16'hA000 + 16'(k);
         check("ovf_drain_data", 48'(data_o), 48'(exp_d));
      end
      ss_pulse();
      check("ovf_drain_count", 48'(count_o), 48'(5'd0));
      check("ovf_drain_sig", 48'(sig_o), 48'(4'b0000));
      check("ovf_sticky", 48'(ovf_o), 48'(1'b1));

      // Snapshot frozen while SPISS is low.
      do_reset();
      ss_n = 1'b0;
      step(4);
      bus_cycle(24'h00ABCE, 16'h5A5A, 1'b1, 1'b0, 1'b0, 2);
      check("frz_count", 48'(count_o), 48'(5'd1));
      check("frz_sig", 48'(sig_o), 48'(4'b0000));
      check("frz_addr", 48'(addr_o), 48'(24'h0));
      ss_n = 1'b1;
      step(2);
      check("frz_sync_sig", 48'(sig_o), 48'(4'b0000));
      step(1);
      check("frz_show_addr", 48'(addr_o), 48'(24'h00ABCE));
      check("frz_show_data", 48'(data_o), 48'(16'h5A5A));
      check("frz_show_sig", 48'(sig_o), 48'(4'b1001));
      check("frz_show_count", 48'(count_o), 48'(5'd0));
      step(1);
      check("frz_after_sig", 48'(sig_o), 48'(4'b0000));

      // Full FIFO with push and pop landing in the same cycle.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         exp_a = 24'h200000 + 24'(2 * i);
         exp_d = 16'hB000 + 16'(i);
         bus_cycle(exp_a, exp_d, 1'b0, 1'b0, 1'b0, 1);
      end
      check("sim_full_count", 48'(count_o), 48'(5'd16));
      check("sim_full_ovf", 48'(ovf_o), 48'(1'b0));
      ss_n = 1'b0;
      step(4);
      cpu_addr = 24'h3FFFFE;
      cpu_data = 16'hCAFE;
      rw       = 1'b0;
      uds_n    = 1'b0;
      lds_n    = 1'b0;
      as_n     = 1'b0;
      step(3);
      dtack_n  = 1'b0;
      step(1);
      ss_n     = 1'b1;
      step(4);
      as_n     = 1'b1;
      dtack_n  = 1'b1;
      uds_n    = 1'b1;
      lds_n    = 1'b1;
      step(5);
      check("sim_count", 48'(count_o), 48'(5'd16));
      check("sim_ovf", 48'(ovf_o), 48'(1'b0));
      check("sim_head_data", 48'(data_o), 48'(16'hB001));
      for (int k = 0; k < 15; k++) begin
         ss_pulse();
      end
      check("sim_new_count", 48'(count_o), 48'(5'd1));
      check("sim_new_addr", 48'(addr_o), 48'(24'h3FFFFE));
      check("sim_new_data", 48'(data_o), 48'(16'hCAFE));
      check("sim_new_sig", 48'(sig_o), 48'(4'b0001));

      // Reset in the middle of a bus cycle and an SPI transaction.
      cpu_addr = 24'h000010;
      cpu_data = 16'h0101;
      as_n     = 1'b0;
      step(3);
      dtack_n  = 1'b0;
      ss_n     = 1'b0;
      step(2);
      rst      = 1'b1;
      step(1);
      check("mid_rst_addr", 48'(addr_o), 48'(24'h0));
      check("mid_rst_data", 48'(data_o), 48'(16'h0));
      check("mid_rst_sig", 48'(sig_o), 48'(4'b0000));
      check("mid_rst_count", 48'(count_o), 48'(5'd0));
      check("mid_rst_ovf", 48'(ovf_o), 48'(1'b0));
      as_n    = 1'b1;
      dtack_n = 1'b1;
      ss_n    = 1'b1;
      step(2);
      rst = 1'b0;
      step(6);
      check("post_rst_count", 48'(count_o), 48'(5'd0));
      check("post_rst_sig", 48'(sig_o), 48'(4'b0000));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_capture_fifo.md
Name: bus_capture_fifo

Overview:
- Upstream feeder for the SPI monitor slave: watches 68000 bus cycles, records one entry per completed cycle (address, data, strobes) into a small FIFO, and presents the oldest entry as a stable snapshot on ADDR/DATA/OUTPUT_SIGNAL.
- The monitor serialises that snapshot on each SPI transaction.
- Each SPISS deassertion (transaction end) pops the presented entry, so the host reads a lossless bus trace instead of a live, racing bus view.

Parameters:
- DEPTH, 16, FIFO entries; power of two, min 2.
- PTR_W, 4, log2(DEPTH); pointer width (count is PTR_W+1 bits).

Ports:
- MCLK_IN  in  1  system clock; all state on rising edge.
- RESET_IN  in  1  synchronous, active-high reset.
- CPU_ADDR_IN  in  24  68000 address bus (bit0 tied 0 by board).
- CPU_DATA_IN  in  16  68000 data bus.
- CPU_AS_N_IN  in  1  address strobe, active low, async to MCLK.
- CPU_UDS_N_IN  in  1  upper data strobe, active low.
- CPU_LDS_N_IN  in  1  lower data strobe, active low.
- CPU_RW_IN  in  1  1=read, 0=write.
- CPU_DTACK_N_IN  in  1  data acknowledge, active low.
- CAPTURE_EN_IN  in  1  1=record cycles; 0=ignore bus, FIFO contents kept.
- SPISS_IN  in  1  monitor SPI slave select, active low, async to MCLK.
- ADDR_OUT  out  24  presented entry address; feeds monitor ADDR_IN.
- DATA_OUT  out  16  presented entry data; feeds monitor DATA_IN.
- OUTPUT_SIGNAL  out  4  {RW, UDS_N, LDS_N, VALID}; feeds monitor OUTPUT_SIGNAL_IN.
- OVERFLOW  out  1  sticky: a cycle was dropped because FIFO full.
- COUNT  out  PTR_W+1  entries stored, 0..DEPTH.

Behaviour:
- Reset (RESET_IN=1 at clock edge): pointers/COUNT=0, OVERFLOW=0, FSM=IDLE, ADDR_OUT=0, DATA_OUT=0, OUTPUT_SIGNAL=4'b0000, sync flops AS/DTACK=1, SS=1. Reset mid-cycle or mid-SPI discards everything, no pop.
- Synchronisers:
  - CPU_AS_N_IN, CPU_DTACK_N_IN, SPISS_IN each pass through 2 flops (as, dtack, ss).
  - Address/data/strobes/RW are sampled unsynchronised, only in SAMPLE state, which is reached after the synced DTACK is low, so the buses are stable.
- Capture FSM:
  - IDLE: if CAPTURE_EN_IN && as==0 -> WAIT_ACK.
  - WAIT_ACK: dtack==0 -> SAMPLE; as==1 (aborted cycle, no DTACK) -> IDLE, nothing recorded.
  - SAMPLE (1 cycle): latch {CPU_ADDR_IN, CPU_DATA_IN, RW, UDS_N, LDS_N}; issue push -> WAIT_END.
  - WAIT_END: as==1 -> IDLE. Exactly one entry per AS assertion.
  - CAPTURE_EN_IN is checked only in IDLE; a cycle already in progress completes.
- Push: writes at wr_ptr when COUNT<DEPTH. When full, the entry is dropped, OVERFLOW<=1 and the FIFO is unchanged. OVERFLOW clears only on reset.
- Pop:
  - Trigger: ss rising edge (previous synced ss=0, current=1), i.e. one SPI transaction finished.
  - If COUNT>0, rd_ptr++ and COUNT--. If empty, no-op.
  - Pointers wrap modulo DEPTH.
- Simultaneous push and pop in one cycle:
  - COUNT unchanged; both pointers advance.
  - If full, the pop frees the slot and the push succeeds; no overflow.
- Presentation register (ADDR_OUT/DATA_OUT/OUTPUT_SIGNAL):
  - Updated every clock while ss==1. Frozen while ss==0, so the snapshot cannot change during a transaction.
  - COUNT>0 after this cycle's push/pop: load head entry, VALID=1.
  - Empty: all zero, VALID=0.
  - Update latency: 1 clock after the FIFO/pointer update.
- Push-to-output latency: entry visible on outputs 2 clocks after SAMPLE when empty and ss==1.
- Storage: DEPTH x 43 bits (24+16+3). May be inferred RAM with registered read, provided the timing above holds.

Test Plan:
- Reset, then write cycle A=0x012344, D=0xBEEF, UDS/LDS low, DTACK after 3 clocks -> COUNT=1, ADDR_OUT=0x012344, DATA_OUT=0xBEEF, OUTPUT_SIGNAL=4'b0001.
- Three reads (0x000100/0x1111, 0x000102/0x2222, 0x000104/0x3333), then three SPISS low/high pulses -> outputs step through each entry in order; after the third pulse OUTPUT_SIGNAL=0, COUNT=0.
- AS asserted then released with no DTACK -> COUNT stays 0, FSM returns IDLE. CAPTURE_EN_IN=0 during a full cycle -> nothing recorded.
- DEPTH+1 completed cycles with no pops -> COUNT=16, OVERFLOW=1, first 16 entries intact. Then one pop -> COUNT=15, OVERFLOW still 1.
- Hold SPISS low, complete a cycle into an empty FIFO -> outputs stay 0 until SPISS high; 2 sync clocks + 1 later, the entry appears. Releasing SPISS also pops it, so COUNT returns to 0.
- Full FIFO, SPISS rising edge synced in the same clock as SAMPLE -> COUNT stays 16, OVERFLOW stays 0, new entry readable after 15 further pops. Assert RESET_IN mid-sequence -> all outputs 0 next clock.
